// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded-form requests (one-hot inst_type, register indices, immediate,
// shamt) into RV32I instruction words. Each word goes into a 2-entry output FIFO, tagged with
// a sequential load address that starts at BASE_ADDR.
// Optional build macro INST_ENC_CHECK_EN: reject immediates that do not fit their format
// (range/alignment). Without it, immediates are truncated silently to their fields.
module inst_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst_type,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  input  logic [4:0]  shamt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        err
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  localparam logic [6:0] F7Zero = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  localparam logic [31:0] InstEbreak = 32'h0010_0073;

  logic [31:0] enc_word;
  logic        type_known;
  logic        legal;
  logic        accept;
  logic        push;
  logic        pop;

  logic [31:0] addr_q;
  logic [31:0] mem_inst_q [2];
  logic [31:0] mem_addr_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;
  logic        err_q;

  // Decode the one-hot type code and pack the fields into an RV32I word.
  always_comb begin
    enc_word   = '0;
    type_known = 1'b1;
    case (inst_type)
      // U-type
      32'h0000_0010: enc_word = {imm[31:12], rd, OpLui};
      32'h0000_0200: enc_word = {imm[31:12], rd, OpAuipc};
      // J-type
      32'h0000_0400: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OpJal};
      // I-type
      32'h0000_0001: enc_word = {imm[11:0], rs1, 3'b000, rd, OpImm};
      32'h0000_0002: enc_word = {imm[11:0], rs1, 3'b000, rd, OpJalr};
      32'h0000_0020: enc_word = {imm[11:0], rs1, 3'b010, rd, OpLoad};
      32'h0000_0040: enc_word = {imm[11:0], rs1, 3'b100, rd, OpLoad};
      32'h0000_1000: enc_word = {imm[11:0], rs1, 3'b010, rd, OpImm};
      32'h0000_2000: enc_word = {imm[11:0], rs1, 3'b011, rd, OpImm};
      // Immediate shifts
      32'h0040_0000: enc_word = {F7Alt, shamt, rs1, 3'b101, rd, OpImm};
      32'h0080_0000: enc_word = {F7Zero, shamt, rs1, 3'b101, rd, OpImm};
      32'h0100_0000: enc_word = {F7Zero, shamt, rs1, 3'b001, rd, OpImm};
      // B-type
      32'h0000_4000: enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OpBranch};
      32'h0000_8000: enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], OpBranch};
      // R-type
      32'h0000_0008: enc_word = {F7Zero, rs2, rs1, 3'b000, rd, OpReg};
      32'h0000_0800: enc_word = {F7Alt, rs2, rs1, 3'b000, rd, OpReg};
      32'h0001_0000: enc_word = {F7Zero, rs2, rs1, 3'b010, rd, OpReg};
      32'h0002_0000: enc_word = {F7Zero, rs2, rs1, 3'b011, rd, OpReg};
      32'h0004_0000: enc_word = {F7Zero, rs2, rs1, 3'b100, rd, OpReg};
      32'h0008_0000: enc_word = {F7Zero, rs2, rs1, 3'b110, rd, OpReg};
      32'h0010_0000: enc_word = {F7Zero, rs2, rs1, 3'b111, rd, OpReg};
      // System
      32'h0000_0004: enc_word = InstEbreak;
      // S-type
      32'h0000_0080: enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OpStore};
      32'h0000_0100: enc_word = {imm[11:5], rs2, rs1, 3'b000, imm[4:0], OpStore};
      32'h0020_0000: enc_word = {imm[11:5], rs2, rs1, 3'b001, imm[4:0], OpStore};
      default:       type_known = 1'b0;
    endcase
  end

`ifdef INST_ENC_CHECK_EN
  // Masks are only consulted once type_known guarantees a single listed bit is set.
  localparam logic [31:0] MaskIs = 32'h0020_31E3;
  localparam logic [31:0] MaskB  = 32'h0000_C000;
  localparam logic [31:0] MaskJ  = 32'h0000_0400;
  localparam logic [31:0] MaskU  = 32'h0000_0210;

  logic imm_ok;

  // Immediate must be representable in its format field (sign bits equal, alignment).
  always_comb begin
    imm_ok = 1'b1;
    if (|(inst_type & MaskIs)) begin
      imm_ok = (&imm[31:11]) | ~(|imm[31:11]);
    end else if (|(inst_type & MaskB)) begin
      imm_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
    end else if (|(inst_type & MaskJ)) begin
      imm_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
    end else if (|(inst_type & MaskU)) begin
      imm_ok = ~(|imm[11:0]);
    end
  end

  assign legal = type_known & imm_ok;
`else
  assign legal = type_known;
`endif

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid & in_ready;
  assign push      = accept & legal;
  assign pop       = out_valid & out_ready;

  assign out_inst = out_valid ? mem_inst_q[rd_ptr_q] : '0;
  assign out_addr = out_valid ? mem_addr_q[rd_ptr_q] : '0;
  assign err      = err_q;

  // FIFO storage, pointers, occupancy and the load-address counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= BASE_ADDR;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_inst_q[wr_ptr_q] <= enc_word;
        mem_addr_q[wr_ptr_q] <= addr_q;
        wr_ptr_q             <= ~wr_ptr_q;
        addr_q               <= addr_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky rejection flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept && !legal) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

  localparam logic [31:0] Base = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst_type;
  logic [4:0]  rd, rs1, rs2, shamt;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        err;

  inst_encoder #(.BASE_ADDR(Base)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst_type(inst_type),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .shamt(shamt), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [63:0] m_q[$];
  logic [31:0] m_addr;
  logic        m_err;

  typedef struct {
    logic [31:0] t;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[9];

  logic [31:0] legal_types[25] = '{
    32'h1, 32'h2, 32'h4, 32'h8, 32'h10, 32'h20, 32'h40, 32'h80, 32'h100, 32'h200, 32'h400,
    32'h800, 32'h1000, 32'h2000, 32'h4000, 32'h8000, 32'h10000, 32'h20000, 32'h40000,
    32'h80000, 32'h100000, 32'h200000, 32'h400000, 32'h800000, 32'h1000000};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural encoder: mnemonic table -> format, then RV32I packing by format.
  function automatic logic [32:0] ref_enc(input logic [31:0] t, input logic [4:0] d,
                                          input logic [4:0] s1, input logic [4:0] s2,
                                          input logic [31:0] im, input logic [4:0] sh);
    string fmt = "";
    logic [6:0] op = '0;
    logic [2:0] f3 = '0;
    logic [6:0] f7 = '0;
    logic [31:0] w = '0;
    logic ok = 1'b1;
    int v = $signed(im);
    case (t)
      32'h1:       begin fmt = "I"; op = 7'h13; f3 = 0; end
      32'h2:       begin fmt = "I"; op = 7'h67; f3 = 0; end
      32'h4:       fmt = "Y";
      32'h8:       begin fmt = "R"; op = 7'h33; f3 = 0; f7 = 0; end
      32'h10:      begin fmt = "U"; op = 7'h37; end
      32'h20:      begin fmt = "I"; op = 7'h03; f3 = 2; end
      32'h40:      begin fmt = "I"; op = 7'h03; f3 = 4; end
      32'h80:      begin fmt = "S"; op = 7'h23; f3 = 2; end
      32'h100:     begin fmt = "S"; op = 7'h23; f3 = 0; end
      32'h200:     begin fmt = "U"; op = 7'h17; end
      32'h400:     begin fmt = "J"; op = 7'h6f; end
      32'h800:     begin fmt = "R"; op = 7'h33; f3 = 0; f7 = 7'h20; end
      32'h1000:    begin fmt = "I"; op = 7'h13; f3 = 2; end
      32'h2000:    begin fmt = "I"; op = 7'h13; f3 = 3; end
      32'h4000:    begin fmt = "B"; op = 7'h63; f3 = 0; end
      32'h8000:    begin fmt = "B"; op = 7'h63; f3 = 1; end
      32'h10000:   begin fmt = "R"; op = 7'h33; f3 = 2; end
      32'h20000:   begin fmt = "R"; op = 7'h33; f3 = 3; end
      32'h40000:   begin fmt = "R"; op = 7'h33; f3 = 4; end
      32'h80000:   begin fmt = "R"; op = 7'h33; f3 = 6; end
      32'h100000:  begin fmt = "R"; op = 7'h33; f3 = 7; end
      32'h200000:  begin fmt = "S"; op = 7'h23; f3 = 1; end
      32'h400000:  begin fmt = "H"; op = 7'h13; f3 = 5; f7 = 7'h20; end
      32'h800000:  begin fmt = "H"; op = 7'h13; f3 = 5; end
      32'h1000000: begin fmt = "H"; op = 7'h13; f3 = 1; end
      default:     ok = 1'b0;
    endcase
    if (fmt == "I") w = {im[11:0], s1, f3, d, op};
    if (fmt == "H") w = {f7, sh, s1, f3, d, op};
    if (fmt == "R") w = {f7, s2, s1, f3, d, op};
    if (fmt == "S") w = {im[11:5], s2, s1, f3, im[4:0], op};
    if (fmt == "B") w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
    if (fmt == "U") w = {im[31:12], d, op};
    if (fmt == "J") w = {im[20], im[10:1], im[11], im[19:12], d, op};
    if (fmt == "Y") w = 32'h0010_0073;
`ifdef INST_ENC_CHECK_EN
    if (fmt == "I" || fmt == "S") ok = (v >= -2048) && (v <= 2047);
    if (fmt == "B") ok = (v >= -4096) && (v <= 4094) && (v % 2 == 0);
    if (fmt == "J") ok = (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
    if (fmt == "U") ok = (im % 4096) == 0;
`else
    if (v == 0) ok = ok;
`endif
    return {ok, w};
  endfunction

  // Compare outputs against the model, advance the model over the next edge, then take it.
  task automatic cycle();
    logic [32:0] r;
    logic acc, pop;
    chk("in_ready", in_ready, m_q.size() != 2);
    chk("out_valid", out_valid, m_q.size() != 0);
    chk("err", err, m_err);
    if (m_q.size() != 0) begin
      chk("out_inst", out_inst, m_q[0][63:32]);
      chk("out_addr", out_addr, m_q[0][31:0]);
    end
    if (rst) begin
      m_q.delete();
      m_addr = Base;
      m_err  = 1'b0;
    end else begin
      acc = in_valid && (m_q.size() < 2);
      pop = (m_q.size() != 0) && out_ready;
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        r = ref_enc(inst_type, rd, rs1, rs2, imm, shamt);
        if (r[32]) begin
          m_q.push_back({r[31:0], m_addr});
          m_addr = m_addr + 32'd4;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [31:0] t, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [31:0] im, input logic [4:0] sh);
    in_valid  = 1'b1;
    inst_type = t;
    rd        = d;
    rs1       = s1;
    rs2       = s2;
    imm       = im;
    shamt     = sh;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  logic [31:0] a0;

  initial begin
    tbl[0] = '{32'h1,      5'd1, 5'd0, 5'd0, 32'd5,        5'd0, 32'h0050_0093};
    tbl[1] = '{32'h80,     5'd0, 5'd1, 5'd2, 32'd8,        5'd0, 32'h0020_A423};
    tbl[2] = '{32'h4000,   5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 5'd0, 32'hFE20_8EE3};
    tbl[3] = '{32'h10,     5'd5, 5'd0, 5'd0, 32'h12345000, 5'd0, 32'h1234_52B7};
    tbl[4] = '{32'h4,      5'd7, 5'd3, 5'd0, 32'h0000FFFF, 5'd0, 32'h0010_0073};
    tbl[5] = '{32'h400000, 5'd3, 5'd4, 5'd0, 32'd0,        5'd7, 32'h4072_5193};
    tbl[6] = '{32'h400,    5'd1, 5'd0, 5'd0, 32'd8,        5'd0, 32'h0080_00EF};
    tbl[7] = '{32'h800,    5'd3, 5'd1, 5'd2, 32'd0,        5'd0, 32'h4020_81B3};
    tbl[8] = '{32'h20,     5'd5, 5'd2, 5'd9, 32'hFFFFFFFC, 5'd0, 32'hFFC1_2283};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    inst_type = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0; shamt = '0;
    repeat (2) @(posedge clk);
    #1;
    m_addr = Base; m_err = 1'b0;
    chk("rst in_ready", in_ready, 1'b1);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst out_inst", out_inst, 32'h0);
    chk("rst out_addr", out_addr, 32'h0);
    chk("rst err", err, 1'b0);
    rst = 1'b0;

    // Table vectors, one request then one idle cycle each, addresses from BASE upward.
    for (int i = 0; i < 9; i++) begin
      set_req(tbl[i].t, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, tbl[i].sh);
      cycle();
      in_valid = 1'b0;
      chk($sformatf("tbl%0d inst", i), out_inst, tbl[i].exp);
      chk($sformatf("tbl%0d addr", i), out_addr, Base + 32'(4 * i));
      cycle();
    end

    // sw then beq back-to-back
    do_reset();
    set_req(32'h80, 5'd0, 5'd1, 5'd2, 32'd8, 5'd0);
    cycle();
    set_req(32'h4000, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 5'd0);
    chk("sw inst", out_inst, 32'h0020_A423);
    chk("sw addr", out_addr, 32'h8000_0000);
    cycle();
    in_valid = 1'b0;
    chk("beq inst", out_inst, 32'hFE20_8EE3);
    chk("beq addr", out_addr, 32'h8000_0004);
    cycle();

    // Backpressure: three requests with out_ready low
    a0 = m_addr;
    out_ready = 1'b0;
    set_req(32'h1, 5'd1, 5'd0, 5'd0, 32'd1, 5'd0);
    cycle();
    set_req(32'h1, 5'd2, 5'd0, 5'd0, 32'd2, 5'd0);
    cycle();
    set_req(32'h1, 5'd3, 5'd0, 5'd0, 32'd3, 5'd0);
    chk("bp in_ready low", in_ready, 1'b0);
    cycle();
    chk("bp held", in_ready, 1'b0);
    chk("bp addr0", out_addr, a0);
    out_ready = 1'b1;
    cycle();
    chk("bp addr1", out_addr, a0 + 32'd4);
    cycle();
    in_valid = 1'b0;
    chk("bp addr2", out_addr, a0 + 32'd8);
    chk("bp inst2", out_inst, 32'h0030_0193);
    cycle();

    // Oversized addi immediate
    set_req(32'h1, 5'd1, 5'd0, 5'd0, 32'd4096, 5'd0);
    cycle();
    in_valid = 1'b0;
`ifdef INST_ENC_CHECK_EN
    chk("imm4096 err", err, 1'b1);
    chk("imm4096 no push", out_valid, 1'b0);
`else
    chk("imm4096 inst", out_inst, 32'h0000_0093);
    chk("imm4096 err", err, 1'b0);
`endif
    cycle();

    // Illegal type, then a legal word reuses the unconsumed address
    a0 = m_addr;
    set_req(32'h3, 5'd1, 5'd1, 5'd1, 32'd0, 5'd0);
    cycle();
    in_valid = 1'b0;
    chk("illegal err", err, 1'b1);
    chk("illegal no out", out_valid, 1'b0);
    set_req(32'h1, 5'd4, 5'd0, 5'd0, 32'd9, 5'd0);
    cycle();
    in_valid = 1'b0;
    chk("after illegal addr", out_addr, a0);
    cycle();

    // Reset mid-stream with two queued words
    out_ready = 1'b0;
    set_req(32'h8, 5'd1, 5'd2, 5'd3, 32'd0, 5'd0);
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst mid out_valid", out_valid, 1'b0);
    chk("rst mid err", err, 1'b0);
    out_ready = 1'b1;
    set_req(32'h1, 5'd1, 5'd0, 5'd0, 32'd5, 5'd0);
    cycle();
    in_valid = 1'b0;
    chk("rst mid addr", out_addr, 32'h8000_0000);
    cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] t, im;
      int sel = $urandom_range(0, 19);
      t = legal_types[$urandom_range(0, 24)];
      if (sel == 0) t = $urandom;
      if (sel == 1) t = t | legal_types[$urandom_range(0, 24)] | 32'h1;
      if (sel == 2) t = 32'h0;
      im = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed(12'($urandom)));
      if ($urandom_range(0, 4) == 0) im = {$urandom_range(0, 32'hFFFFF), 12'h000};
      set_req(t, 5'($urandom), 5'($urandom), 5'($urandom), im, 5'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 59) == 0);
      cycle();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Instruction encoder for the NPC test infrastructure: the inverse of the decode stage. It accepts decoded-form requests (the one-hot `inst_type` code, register indices, sign-extended immediate, shamt) over a valid/ready handshake and packs them into 32-bit RV32 instruction words. Each word goes through a 2-entry output FIFO, tagged with a sequential load address, so a bench or boot loader can stream generated programs into instruction memory.

## Interface
- `BASE_ADDR`, default 32'h80000000: address tagged on the first emitted word after reset.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: request present.
- `in_ready` output 1: encoder can accept a request.
- `inst_type` input 32: one-hot type code, same values the decode stage produces.
- `rd`, `rs1`, `rs2` input 5 each: register indices.
- `imm` input 32: immediate in decoded form. I/S/B/J are sign-extended byte offsets. U is the full value with [11:0] zero.
- `shamt` input 5: shift amount for slli/srli/srai.
- `out_valid` output 1: encoded word available.
- `out_ready` input 1: consumer takes the word.
- `out_inst` output 32: encoded instruction.
- `out_addr` output 32: address of `out_inst`.
- `err` output 1: sticky; a request was rejected.

## Operation
- Type codes:
  - U: lui 0x10, auipc 0x200.
  - J: jal 0x400.
  - I: addi 0x1, jalr 0x2, lw 0x20, lbu 0x40, slti 0x1000, sltiu 0x2000.
  - Shifts: srai 0x400000, srli 0x800000, slli 0x1000000.
  - B: beq 0x4000, bne 0x8000.
  - R: add 0x8, sub 0x800, slt 0x10000, sltu 0x20000, xor 0x40000, or 0x80000, and 0x100000.
  - System: ebreak 0x4.
  - S: sw 0x80, sb 0x100, sh 0x200000.
- Field packing uses standard RV32I formats with the matching opcode, funct3 and funct7:
  - Shifts: [24:20]=shamt; srai funct7=0100000.
  - ebreak: constant 32'h00100073; all fields ignored.
  - U: [31:12]=imm[31:12].
  - J: imm[20|10:1|11|19:12]. B: imm[12|10:5] and [4:1|11]. S: imm[11:5] and [4:0].
- Unused fields (rs2 for I-type, rs1/rs2 for U/J) are forced to zero in the word.
- Handshake: accept when `in_valid && in_ready`.
  - A legal request is encoded combinationally and pushed into the FIFO with the current address counter. The counter then advances by 4 (mod 2^32).
  - An illegal request is accepted (consumed) but not pushed. It sets `err` and leaves the counter unchanged.
- Illegal request: any `inst_type` not listed above, including zero and multi-hot values.
- FIFO: 2 entries, count 0..2; `in_ready = (count != 2)`.
  - Pop when `out_valid && out_ready`.
  - Simultaneous push and pop at count 1: count stays 1, order is preserved.
  - `out_valid = (count != 0)`.
  - `out_inst`/`out_addr` are stable while `out_valid && !out_ready`.
- `err`: set on any rejection, cleared only by `rst`.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_inst`=0, `out_addr`=0, `err`=0; FIFO empty; address counter=`BASE_ADDR`.
- Latency: a request accepted at edge N appears on `out_*` in the cycle after edge N, if the FIFO was empty.
- Throughput: 1 word/cycle while `out_ready`=1.
- `err` rises in the cycle after the rejecting accept edge.
- Reset asserted mid-stream: FIFO contents are discarded and the counter returns to `BASE_ADDR` at that edge. Requests presented during reset are not accepted.
- Counter wrap: 0xFFFFFFFC + 4 → 0x00000000, no error.

## Configuration
- `INST_ENC_CHECK_EN` defined: immediate range and alignment checks are enforced. Failing requests are rejected as illegal (`err` set, no push). Required conditions:
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
- `INST_ENC_CHECK_EN` undefined: immediates are truncated silently to their format fields; only unknown types raise `err`.

## Test plan
- addi: type 0x1, rd=1, rs1=0, imm=5 after reset → `out_inst`=0x00500093, `out_addr`=0x80000000, one cycle later.
- sw then beq back-to-back with `out_ready`=1:
  - sw: type 0x80, rs1=1, rs2=2, imm=8 → 0x0020A423 @0x80000000.
  - beq: type 0x4000, rs1=1, rs2=2, imm=0xFFFFFFFC → 0xFE208EE3 @0x80000004.
- lui: type 0x10, rd=5, imm=0x12345000 → 0x123452B7. ebreak: type 0x4 → 0x00100073.
- Backpressure: `out_ready`=0 with 3 consecutive requests → `in_ready` drops after the 2nd accept and the 3rd is held. Raising `out_ready` drains the words in order at addresses +0, +4, +8.
- Illegal: type 0x3 → `err`=1, no output, next legal word reuses the unconsumed address. With `INST_ENC_CHECK_EN`, addi imm=4096 → `err`=1; without it → imm field 0x000.
- Reset mid-stream with 2 words queued → `out_valid`=0 next cycle; next word tagged 0x80000000.
